// File: rtl/detector_nota.sv
// Tone decoder: measures the period of a square-wave note in clk cycles and
// reports the confirmed note DO..SI as a one-hot key vector.
module detector_nota #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned CNT_W    = 17,
  parameter int unsigned TIMEOUT  = 100_000,
  parameter int unsigned CONFIRM  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  output logic [6:0]       teclas,
  output logic             nota_valida,
  output logic [CNT_W-1:0] periodo
);

  // Nominal periods of each note, DO lowest pitch (longest period)
  localparam int unsigned P_DO  = CLK_FREQ / 1046;
  localparam int unsigned P_RE  = CLK_FREQ / 1174;
  localparam int unsigned P_MI  = CLK_FREQ / 1318;
  localparam int unsigned P_FA  = CLK_FREQ / 1396;
  localparam int unsigned P_SOL = CLK_FREQ / 1567;
  localparam int unsigned P_LA  = CLK_FREQ / 1760;
  localparam int unsigned P_SI  = CLK_FREQ / 1975;

  // Band edges: inclusive lower bound, exclusive upper bound
  localparam int unsigned B_LO     = P_SI - (P_LA - P_SI) / 2;
  localparam int unsigned B_SI_LA  = (P_SI + P_LA) / 2;
  localparam int unsigned B_LA_SOL = (P_LA + P_SOL) / 2;
  localparam int unsigned B_SOL_FA = (P_SOL + P_FA) / 2;
  localparam int unsigned B_FA_MI  = (P_FA + P_MI) / 2;
  localparam int unsigned B_MI_RE  = (P_MI + P_RE) / 2;
  localparam int unsigned B_RE_DO  = (P_RE + P_DO) / 2;
  localparam int unsigned B_HI     = P_DO + (P_DO - P_RE) / 2;

  localparam logic [CNT_W-1:0] E0 = CNT_W'(B_LO);
  localparam logic [CNT_W-1:0] E1 = CNT_W'(B_SI_LA);
  localparam logic [CNT_W-1:0] E2 = CNT_W'(B_LA_SOL);
  localparam logic [CNT_W-1:0] E3 = CNT_W'(B_SOL_FA);
  localparam logic [CNT_W-1:0] E4 = CNT_W'(B_FA_MI);
  localparam logic [CNT_W-1:0] E5 = CNT_W'(B_MI_RE);
  localparam logic [CNT_W-1:0] E6 = CNT_W'(B_RE_DO);
  localparam logic [CNT_W-1:0] E7 = CNT_W'(B_HI);

  localparam logic [CNT_W-1:0] TO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);

  localparam int unsigned      MC_W    = (CONFIRM < 1) ? 1 : $clog2(CONFIRM + 1);
  localparam logic [MC_W-1:0]  MC_CONF = MC_W'(CONFIRM);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  // Class index equals the teclas bit; 7 means no note
  localparam logic [2:0] CLS_NONE = 3'd7;

  logic             sync1_q, sync2_q, sync3_q;
  logic             rise_c;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_c;
  logic [2:0]       cls_c;

  logic [1:0]       state_q, state_d;
  logic [2:0]       cand_q, cand_d;
  logic [MC_W-1:0]  mcnt_q, mcnt_d, mcnt_new_c;
  logic [6:0]       teclas_d;
  logic             valida_d;
  logic [CNT_W-1:0] periodo_d;

  // Two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= tone_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise_c = sync2_q & ~sync3_q;

  // Period counter: restarts at 1 on each rise, saturates at TIMEOUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (rise_c) begin
      cnt_q <= CNT_W'(1);
    end else if (cnt_q < TO) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Fires on the cycle where the counter is about to reach TIMEOUT
  assign timeout_c = (state_q != S_IDLE) && !rise_c && (cnt_q >= TO_M1);

  always_comb begin
    cls_c = CLS_NONE;
    if      (cnt_q >= E0 && cnt_q < E1) cls_c = 3'd6;
    else if (cnt_q >= E1 && cnt_q < E2) cls_c = 3'd5;
    else if (cnt_q >= E2 && cnt_q < E3) cls_c = 3'd4;
    else if (cnt_q >= E3 && cnt_q < E4) cls_c = 3'd3;
    else if (cnt_q >= E4 && cnt_q < E5) cls_c = 3'd2;
    else if (cnt_q >= E5 && cnt_q < E6) cls_c = 3'd1;
    else if (cnt_q >= E6 && cnt_q < E7) cls_c = 3'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cand_q      <= CLS_NONE;
      mcnt_q      <= '0;
      teclas      <= '0;
      nota_valida <= 1'b0;
      periodo     <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      mcnt_q      <= mcnt_d;
      teclas      <= teclas_d;
      nota_valida <= valida_d;
      periodo     <= periodo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    mcnt_d     = mcnt_q;
    mcnt_new_c = mcnt_q;
    teclas_d   = teclas;
    valida_d   = nota_valida;
    periodo_d  = periodo;

    case (state_q)
      S_IDLE: begin
        if (rise_c) begin
          state_d = S_ARMED;
          cand_d  = CLS_NONE;
          mcnt_d  = '0;
        end
      end

      S_ARMED, S_LOCKED: begin
        if (rise_c) begin
          periodo_d = cnt_q;
          // A zero match count means no candidate yet, even if cand_q matches
          if ((mcnt_q != '0) && (cls_c == cand_q)) begin
            mcnt_new_c = (mcnt_q >= MC_CONF) ? MC_CONF : mcnt_q + MC_W'(1);
          end else begin
            cand_d     = cls_c;
            mcnt_new_c = MC_W'(1);
          end
          mcnt_d = mcnt_new_c;
          if (mcnt_new_c == MC_CONF) begin
            if (cls_c == CLS_NONE) begin
              teclas_d = '0;
              valida_d = 1'b0;
              state_d  = S_ARMED;
            end else begin
              teclas_d = 7'b1 << cls_c;
              valida_d = 1'b1;
              state_d  = S_LOCKED;
            end
          end
        end else if (timeout_c) begin
          teclas_d = '0;
          valida_d = 1'b0;
          cand_d   = CLS_NONE;
          mcnt_d   = '0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        teclas_d = '0;
        valida_d = 1'b0;
        cand_d   = CLS_NONE;
        mcnt_d   = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_detector_nota.sv
// Bench for detector_nota: scaled clock so every period fits a short run,
// outputs checked against a period-history reference model.
module tb_detector_nota;

  localparam int CLK_FREQ = 500_000;
  localparam int CNT_W    = 10;
  localparam int TIMEOUT  = 1000;
  localparam int CONFIRM  = 2;
  localparam int NONE     = 7;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             tone_in = 1'b0;
  logic [6:0]       teclas;
  logic             nota_valida;
  logic [CNT_W-1:0] periodo;

  int checks = 0;
  int errors = 0;

  int freqs [7] = '{1046, 1174, 1318, 1396, 1567, 1760, 1975};

  // Reference model state
  bit               m_active = 1'b0;
  int               hist[$];
  int               prev_len = 0;
  logic [6:0]       exp_teclas = '0;
  logic             exp_valid  = 1'b0;
  logic [CNT_W-1:0] exp_per    = '0;

  detector_nota #(
    .CLK_FREQ(CLK_FREQ),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .CONFIRM (CONFIRM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tone_in    (tone_in),
    .teclas     (teclas),
    .nota_valida(nota_valida),
    .periodo    (periodo)
  );

  always #5 clk = ~clk;

  function automatic int nom(input int i);
    return CLK_FREQ / freqs[i];
  endfunction

  function automatic int band_lo(input int i);
    if (i == 6) return nom(6) - (nom(5) - nom(6)) / 2;
    return (nom(i) + nom(i + 1)) / 2;
  endfunction

  function automatic int band_hi(input int i);
    if (i == 0) return nom(0) + (nom(0) - nom(1)) / 2;
    return (nom(i - 1) + nom(i)) / 2;
  endfunction

  function automatic int classify(input int p);
    for (int i = 0; i < 7; i++)
      if (p >= band_lo(i) && p < band_hi(i)) return i;
    return NONE;
  endfunction

  // Output follows the last CONFIRM classifications once they all agree
  task automatic model_rise();
    int  c;
    bit  same;
    if (!m_active) begin
      m_active = 1'b1;
      hist.delete();
    end else begin
      exp_per = CNT_W'(prev_len);
      hist.push_back(classify(prev_len));
      if (hist.size() >= CONFIRM) begin
        c    = hist[hist.size() - 1];
        same = 1'b1;
        for (int i = 1; i < CONFIRM; i++)
          if (hist[hist.size() - 1 - i] != c) same = 1'b0;
        if (same) begin
          if (c == NONE) begin
            exp_teclas = '0;
            exp_valid  = 1'b0;
          end else begin
            exp_teclas = 7'(1 << c);
            exp_valid  = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic model_silence();
    m_active   = 1'b0;
    hist.delete();
    exp_teclas = '0;
    exp_valid  = 1'b0;
  endtask

  // One tone period of n cycles starting with a rise; samples outputs one
  // cycle before and right at the expected update edge.
  task automatic drive_period(input int n,
                              output logic [6:0] t_pre, output logic v_pre,
                              output logic [6:0] t_post, output logic v_post,
                              output logic [CNT_W-1:0] p_post);
    model_rise();
    prev_len = n;
    tone_in  = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == n / 2) tone_in = 1'b0;
      if (c == 2) begin
        t_pre = teclas;
        v_pre = nota_valida;
      end
      if (c == 3) begin
        t_post = teclas;
        v_post = nota_valida;
        p_post = periodo;
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    tone_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({teclas, nota_valida, periodo} !== {7'd0, 1'b0, CNT_W'(0)}) begin
      errors++;
      $display("FAIL reset: teclas=%b valida=%b periodo=%0d, required 0/0/0",
               teclas, nota_valida, periodo);
    end
    rst_n = 1'b1;
    model_silence();
    exp_per = '0;
    @(negedge clk);
  endtask

  task automatic test_do_lock();
    logic [6:0] t0, t1; logic v0, v1; logic [CNT_W-1:0] p1;
    logic [6:0] bt; logic bv;
    for (int i = 0; i < 4; i++) begin
      bt = exp_teclas; bv = exp_valid;
      drive_period(nom(0), t0, v0, t1, v1, p1);
      checks += 3;
      if ({t0, v0} !== {bt, bv}) begin
        errors++;
        $display("FAIL do_pre[%0d]: %b/%b, required %b/%b", i, t0, v0, bt, bv);
      end
      if ({t1, v1} !== {exp_teclas, exp_valid}) begin
        errors++;
        $display("FAIL do_post[%0d]: %b/%b, required %b/%b", i, t1, v1, exp_teclas, exp_valid);
      end
      if (p1 !== exp_per) begin
        errors++;
        $display("FAIL do_periodo[%0d]: %0d, required %0d", i, p1, exp_per);
      end
      checks++;
      if (i == 1 && p1 !== CNT_W'(nom(0))) begin
        errors++;
        $display("FAIL do_edge2_periodo: %0d, required %0d", p1, nom(0));
      end else if (i < 2 && t1 !== 7'd0) begin
        errors++;
        $display("FAIL do_early: teclas=%b, required 0", t1);
      end else if (i >= 2 && {t1, v1} !== {7'b0000001, 1'b1}) begin
        errors++;
        $display("FAIL do_lock[%0d]: %b/%b, required 0000001/1", i, t1, v1);
      end
    end
  endtask

  task automatic test_switch_si();
    logic [6:0] t0, t1; logic v0, v1; logic [CNT_W-1:0] p1;
    logic [6:0] bt; logic bv;
    for (int j = 0; j < 4; j++) begin
      bt = exp_teclas; bv = exp_valid;
      drive_period(nom(6), t0, v0, t1, v1, p1);
      checks += 3;
      if ({t0, v0} !== {bt, bv}) begin
        errors++;
        $display("FAIL si_pre[%0d]: %b/%b, required %b/%b", j, t0, v0, bt, bv);
      end
      if ({t1, v1} !== {exp_teclas, exp_valid} || p1 !== exp_per) begin
        errors++;
        $display("FAIL si_model[%0d]: %b/%b/%0d, required %b/%b/%0d",
                 j, t1, v1, p1, exp_teclas, exp_valid, exp_per);
      end
      if ((j == 1 && t1 !== 7'b0000001) || (j >= 2 && t1 !== 7'b1000000)) begin
        errors++;
        $display("FAIL si_switch[%0d]: teclas=%b", j, t1);
      end
    end
  endtask

  task automatic test_boundaries();
    int         bp [6];
    logic [6:0] bx [6];
    logic [6:0] t0, t1; logic v0, v1; logic [CNT_W-1:0] p1;
    bp[0] = band_lo(0);     bx[0] = 7'b0000001;
    bp[1] = band_lo(0) - 1; bx[1] = 7'b0000010;
    bp[2] = band_lo(6) - 1; bx[2] = 7'b0000000;
    bp[3] = band_lo(6);     bx[3] = 7'b1000000;
    bp[4] = band_hi(0) - 1; bx[4] = 7'b0000001;
    bp[5] = band_hi(0);     bx[5] = 7'b0000000;
    for (int k = 0; k < 6; k++) begin
      for (int r = 0; r < 3; r++) begin
        drive_period(bp[k], t0, v0, t1, v1, p1);
        checks++;
        if ({t1, v1} !== {exp_teclas, exp_valid} || p1 !== exp_per) begin
          errors++;
          $display("FAIL bound_model[%0d.%0d]: %b/%b/%0d, required %b/%b/%0d",
                   k, r, t1, v1, p1, exp_teclas, exp_valid, exp_per);
        end
      end
      checks++;
      if ({t1, v1} !== {bx[k], (bx[k] != 7'd0)}) begin
        errors++;
        $display("FAIL bound_%0d(period %0d): %b/%b, required %b", k, bp[k], t1, v1, bx[k]);
      end
    end
  endtask

  task automatic test_glitch();
    int         seq [7];
    logic [6:0] t0, t1; logic v0, v1; logic [CNT_W-1:0] p1;
    seq = '{nom(5), nom(5), nom(5), 100, nom(5), nom(5), nom(5)};
    for (int i = 0; i < 7; i++) begin
      drive_period(seq[i], t0, v0, t1, v1, p1);
      checks++;
      if ({t1, v1} !== {exp_teclas, exp_valid} || p1 !== exp_per) begin
        errors++;
        $display("FAIL glitch_model[%0d]: %b/%b/%0d, required %b/%b/%0d",
                 i, t1, v1, p1, exp_teclas, exp_valid, exp_per);
      end
      if (i >= 3) begin
        checks++;
        if (t0 !== 7'b0100000 || t1 !== 7'b0100000) begin
          errors++;
          $display("FAIL glitch_hold[%0d]: %b then %b, required 0100000", i, t0, t1);
        end
      end
      if (i == 4) begin
        checks++;
        if (p1 !== CNT_W'(100)) begin
          errors++;
          $display("FAIL glitch_periodo: %0d, required 100", p1);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [6:0] t0, t1; logic v0, v1; logic [CNT_W-1:0] p1;
    for (int i = 0; i < 3; i++) drive_period(nom(2), t0, v0, t1, v1, p1);
    checks++;
    if ({t1, v1} !== {7'b0000100, 1'b1}) begin
      errors++;
      $display("FAIL mi_lock: %b/%b, required 0000100/1", t1, v1);
    end
    // Last rise, then silence
    model_rise();
    tone_in = 1'b1;
    for (int c = 1; c <= TIMEOUT + 4; c++) begin
      @(negedge clk);
      if (c == nom(2) / 2) tone_in = 1'b0;
      if (c == TIMEOUT + 1) begin
        checks++;
        if ({teclas, nota_valida} !== {7'b0000100, 1'b1}) begin
          errors++;
          $display("FAIL timeout_early: %b/%b, required 0000100/1", teclas, nota_valida);
        end
      end
      if (c == TIMEOUT + 2) begin
        checks += 2;
        if ({teclas, nota_valida} !== {7'd0, 1'b0}) begin
          errors++;
          $display("FAIL timeout_clear: %b/%b, required 0/0", teclas, nota_valida);
        end
        if (periodo !== CNT_W'(nom(2))) begin
          errors++;
          $display("FAIL timeout_periodo: %0d, required %0d", periodo, nom(2));
        end
      end
    end
    model_silence();
    for (int i = 0; i < 3; i++) begin
      drive_period(nom(2), t0, v0, t1, v1, p1);
      checks += 2;
      if ({t1, v1} !== {exp_teclas, exp_valid} || p1 !== exp_per) begin
        errors++;
        $display("FAIL relock_model[%0d]: %b/%b/%0d, required %b/%b/%0d",
                 i, t1, v1, p1, exp_teclas, exp_valid, exp_per);
      end
      if ((i < 2 && t1 !== 7'd0) || (i == 2 && t1 !== 7'b0000100)) begin
        errors++;
        $display("FAIL relock_edge[%0d]: teclas=%b", i, t1);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] t0, t1; logic v0, v1; logic [CNT_W-1:0] p1;
    for (int i = 0; i < 3; i++) drive_period(nom(4), t0, v0, t1, v1, p1);
    tone_in = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ({teclas, nota_valida} !== {7'b0010000, 1'b1}) begin
      errors++;
      $display("FAIL sol_lock: %b/%b, required 0010000/1", teclas, nota_valida);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({teclas, nota_valida, periodo} !== {7'd0, 1'b0, CNT_W'(0)}) begin
      errors++;
      $display("FAIL async_reset: %b/%b/%0d, required 0/0/0", teclas, nota_valida, periodo);
    end
    tone_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_silence();
    exp_per = '0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive_period(nom(4), t0, v0, t1, v1, p1);
      checks += 2;
      if ({t1, v1} !== {exp_teclas, exp_valid} || p1 !== exp_per) begin
        errors++;
        $display("FAIL rst_relock_model[%0d]: %b/%b/%0d, required %b/%b/%0d",
                 i, t1, v1, p1, exp_teclas, exp_valid, exp_per);
      end
      if ((i < 2 && t1 !== 7'd0) || (i >= 2 && t1 !== 7'b0010000)) begin
        errors++;
        $display("FAIL rst_relock_edge[%0d]: teclas=%b", i, t1);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] t0, t1; logic v0, v1; logic [CNT_W-1:0] p1;
    logic [6:0] bt; logic bv;
    int note, reps, p;
    for (int n = 0; n < 30; n++) begin
      note = int'($urandom_range(0, 6));
      reps = int'($urandom_range(1, 3));
      for (int r = 0; r < reps; r++) begin
        p = nom(note) + int'($urandom_range(0, 6)) - 3;
        if ($urandom_range(0, 7) == 0) p = int'($urandom_range(60, 900));
        bt = exp_teclas; bv = exp_valid;
        drive_period(p, t0, v0, t1, v1, p1);
        checks += 2;
        if ({t0, v0} !== {bt, bv}) begin
          errors++;
          $display("FAIL rand_pre[%0d]: %b/%b, required %b/%b", n, t0, v0, bt, bv);
        end
        if ({t1, v1} !== {exp_teclas, exp_valid} || p1 !== exp_per) begin
          errors++;
          $display("FAIL rand_post[%0d] period %0d: %b/%b/%0d, required %b/%b/%0d",
                   n, p, t1, v1, p1, exp_teclas, exp_valid, exp_per);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_do_lock();
    test_switch_si();
    test_boundaries();
    test_glitch();
    test_timeout();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
